// File: rtl/btn_event_gen_pkg.sv
// Shared game-board button definitions: index map, default timing, repeat FSM states.
// Also holds the lowest-set-bit helper used by the event arbiter.
package btn_event_gen_pkg;

    localparam int N_BTN     = 5;
    localparam int BTN_LEFT  = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_ENTER = 4;

    localparam int DEF_DEB_CYCLES    = 5000;
    localparam int DEF_REPEAT_DELAY  = 250000;
    localparam int DEF_REPEAT_PERIOD = 50000;
    localparam int DEF_CNT_W         = 20;

    localparam logic [1:0] REP_IDLE   = 2'd0;
    localparam logic [1:0] REP_DELAY  = 2'd1;
    localparam logic [1:0] REP_REPEAT = 2'd2;

    function automatic logic [N_BTN-1:0] lowest_set(input logic [N_BTN-1:0] v);
        return v & (~v + {{(N_BTN-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/btn_event_gen_if.sv
// Pin-side and game-logic-side signals of the button front end.
// The master side drives pins and repeat enables; the slave side is the front end.
interface btn_event_gen_if;
    import btn_event_gen_pkg::*;

    logic [N_BTN-1:0] BTN_RAW;
    logic [N_BTN-1:0] REPEAT_EN;
    logic [N_BTN-1:0] BTN_PRESSED;
    logic [N_BTN-1:0] BTN_EDGE;
    logic             EVT_DROPPED;

    modport master (output BTN_RAW, output REPEAT_EN,
                    input  BTN_PRESSED, input BTN_EDGE, input EVT_DROPPED);
    modport slave  (input  BTN_RAW, input REPEAT_EN,
                    output BTN_PRESSED, output BTN_EDGE, output EVT_DROPPED);
endinterface

// File: rtl/btn_event_gen_channel.sv
// One button: 2-FF synchroniser, debounce, hold-to-repeat FSM; evt_req is a same-edge request.
// Level settles 2+DEB_CYCLES edges after the pin; no backpressure, requests are never held here.
module btn_channel
    import btn_event_gen_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_n,
    input  logic repeat_en,
    output logic pressed,
    output logic evt_req
);

    localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] DLY_TERM = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_TERM = CNT_W'(REPEAT_PERIOD - 1);

    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             pressed_q, pressed_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]       state_q, state_d;
    logic             rise, fall;

    always_comb begin
        sync1_d   = btn_raw_n;
        sync2_d   = sync1_q;
        pressed_d = pressed_q;
        deb_cnt_d = '0;
        // The counter must already sit at DEB_CYCLES when the level flips.
        if (~sync2_q != pressed_q) begin
            if (deb_cnt_q == DEB_TERM) begin
                pressed_d = ~pressed_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        rise = pressed_d & ~pressed_q;
        fall = ~pressed_d & pressed_q;

        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        evt_req   = 1'b0;
        if (fall) begin
            state_d   = REP_IDLE;
            rep_cnt_d = '0;
        end else begin
            case (state_q)
                REP_IDLE: begin
                    if (rise) begin
                        evt_req   = 1'b1;
                        state_d   = REP_DELAY;
                        rep_cnt_d = '0;
                    end
                end
                REP_DELAY: begin
                    if (rep_cnt_q == DLY_TERM) begin
                        if (repeat_en) begin
                            evt_req   = 1'b1;
                            state_d   = REP_REPEAT;
                            rep_cnt_d = '0;
                        end
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                REP_REPEAT: begin
                    // Disabling parks at the delay terminal so re-enabling fires at once.
                    if (!repeat_en) begin
                        state_d   = REP_DELAY;
                        rep_cnt_d = DLY_TERM;
                    end else if (rep_cnt_q == PER_TERM) begin
                        evt_req   = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = REP_IDLE;
                    rep_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            pressed_q <= 1'b0;
            deb_cnt_q <= '0;
            rep_cnt_q <= '0;
            state_q   <= REP_IDLE;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pressed_q <= pressed_d;
            deb_cnt_q <= deb_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            state_q   <= state_d;
        end
    end

    assign pressed = pressed_q;

endmodule

// File: rtl/btn_event_gen.sv
// Five-button front end: per-button channels, pending bits, lowest-index arbiter, drop flag.
// Event pulses one edge after the request when uncontended; no backpressure, repeats onto a pending event are dropped.
module btn_event_gen
    import btn_event_gen_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic          CLK,
    input  logic          RST,
    btn_event_gen_if.slave bus
);

    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] req;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] edge_q, edge_d;
    logic [N_BTN-1:0] grant;
    logic             drop_q, drop_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .DEB_CYCLES    (DEB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .CNT_W         (CNT_W)
        ) u_chan (
            .clk       (CLK),
            .rst       (RST),
            .btn_raw_n (bus.BTN_RAW[i]),
            .repeat_en (bus.REPEAT_EN[i]),
            .pressed   (pressed[i]),
            .evt_req   (req[i])
        );
    end

    always_comb begin
        grant     = lowest_set(pending_q);
        edge_d    = grant;
        // A request landing on its own grant survives as the next pending event.
        pending_d = (pending_q & ~grant) | req;
        drop_d    = |(req & pending_q & ~grant);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_q <= '0;
            edge_q    <= '0;
            drop_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            edge_q    <= edge_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.BTN_PRESSED = pressed;
    assign bus.BTN_EDGE    = edge_q;
    assign bus.EVT_DROPPED = drop_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen with short timing; outputs are checked against an event-level model.
module tb_btn_event_gen;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam logic [4:0] REL = 5'h1f;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    btn_event_gen_if bus ();

    btn_event_gen #(
        .DEB_CYCLES    (DEB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .CNT_W         (20)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Reference model: pin-sample window for debounce, due-time rules for repeats,
    // lowest-index-first service of outstanding events.
    logic [4:0] hist [0:DEB+2];
    logic [4:0] m_lvl, m_edge, m_pend;
    logic       m_drop;
    int         due [5];
    bit         rep [5];
    int         cyc = 0;

    task automatic model_edge(input logic r, input logic [4:0] pins, input logic [4:0] en);
        logic [4:0] rq, gr;
        bit         all_diff;
        rq = '0;
        gr = '0;
        if (r) begin
            for (int j = 0; j <= DEB + 2; j++) hist[j] = REL;
            m_lvl = '0; m_edge = '0; m_pend = '0; m_drop = 1'b0;
            for (int b = 0; b < 5; b++) begin due[b] = 0; rep[b] = 0; end
        end else begin
            for (int j = 0; j < DEB + 2; j++) hist[j] = hist[j+1];
            hist[DEB+2] = pins;
            for (int b = 0; b < 5; b++) if (m_pend[b] && gr == '0) gr[b] = 1'b1;
            for (int b = 0; b < 5; b++) begin
                all_diff = 1;
                for (int j = 0; j <= DEB; j++) if ((~hist[j][b]) == m_lvl[b]) all_diff = 0;
                if (all_diff) begin
                    m_lvl[b] = ~m_lvl[b];
                    if (m_lvl[b]) begin rq[b] = 1'b1; due[b] = cyc + RD; rep[b] = 0; end
                end else if (m_lvl[b]) begin
                    if (cyc >= due[b] && en[b]) begin
                        rq[b] = 1'b1; due[b] = cyc + RP; rep[b] = 1;
                    end else if (rep[b] && !en[b]) begin
                        due[b] = cyc + 1;
                    end
                end
            end
            m_drop = |(rq & m_pend & ~gr);
            m_pend = (m_pend & ~gr) | rq;
            m_edge = gr;
        end
    endtask

    task automatic step(input logic r, input logic [4:0] pins, input logic [4:0] en);
        rst           = r;
        bus.BTN_RAW   = pins;
        bus.REPEAT_EN = en;
        @(posedge clk);
        model_edge(r, pins, en);
        cyc++;
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, REL, 5'h00);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 52; i++) begin
            step(i < 2, REL, 5'($urandom));
            tests++;
            if (bus.BTN_PRESSED !== 5'h0 || bus.BTN_EDGE !== 5'h0 || bus.EVT_DROPPED !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle i=%0d: pressed=%b edge=%b drop=%b, required all 0",
                         i, bus.BTN_PRESSED, bus.BTN_EDGE, bus.EVT_DROPPED);
            end
        end
    endtask

    task automatic test_single_press;
        logic [4:0] exp_e;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, REL & ~5'b00100, 5'h00);
            exp_e = (i == 7) ? 5'b00100 : 5'b00000;
            tests++;
            if (bus.BTN_PRESSED[2] !== (i >= 6) || bus.BTN_EDGE !== exp_e || bus.BTN_PRESSED !== m_lvl) begin
                fails++;
                $display("FAIL single_press i=%0d: pressed=%b edge=%b, required pressed[2]=%0d edge=%b level=%b",
                         i, bus.BTN_PRESSED, bus.BTN_EDGE, (i >= 6), exp_e, m_lvl);
            end
        end
        settle(12);
    endtask

    task automatic test_repeat;
        logic [4:0] exp_e;
        for (int i = 0; i < 58; i++) begin
            step(1'b0, REL & ~5'b01000, 5'b01000);
            exp_e = (i == 7 || (i >= 27 && (i - 27) % 8 == 0)) ? 5'b01000 : 5'b00000;
            tests++;
            if (bus.BTN_EDGE !== exp_e || bus.BTN_EDGE !== m_edge) begin
                fails++;
                $display("FAIL repeat_hold i=%0d: edge=%b, required %b (model %b)", i, bus.BTN_EDGE, exp_e, m_edge);
            end
        end
        for (int j = 0; j < 12; j++) begin
            step(1'b0, REL, 5'b01000);
            tests++;
            if (bus.BTN_PRESSED[3] !== (j < 6) || bus.BTN_EDGE !== m_edge || bus.EVT_DROPPED !== m_drop) begin
                fails++;
                $display("FAIL repeat_release j=%0d: pressed=%b edge=%b drop=%b, required pressed[3]=%0d edge=%b drop=%b",
                         j, bus.BTN_PRESSED, bus.BTN_EDGE, bus.EVT_DROPPED, (j < 6), m_edge, m_drop);
            end
        end
        settle(12);
    endtask

    task automatic test_glitch;
        int len;
        len = $urandom_range(1, DEB - 1);
        for (int i = 0; i < len + 12; i++) begin
            step(1'b0, (i < len) ? (REL & ~5'b10000) : REL, 5'h1f);
            tests++;
            if (bus.BTN_PRESSED !== 5'h0 || bus.BTN_EDGE !== 5'h0 || bus.BTN_PRESSED !== m_lvl) begin
                fails++;
                $display("FAIL glitch len=%0d i=%0d: pressed=%b edge=%b, required 0 0", len, i,
                         bus.BTN_PRESSED, bus.BTN_EDGE);
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [4:0] exp_e;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, REL & ~5'b00101, 5'h00);
            exp_e = (i == 7) ? 5'b00001 : (i == 8) ? 5'b00100 : 5'b00000;
            tests++;
            if (bus.BTN_EDGE !== exp_e || bus.BTN_EDGE !== m_edge || bus.BTN_PRESSED !== m_lvl) begin
                fails++;
                $display("FAIL simultaneous i=%0d: edge=%b pressed=%b, required edge=%b pressed=%b",
                         i, bus.BTN_EDGE, bus.BTN_PRESSED, exp_e, m_lvl);
            end
        end
        settle(12);
    endtask

    task automatic test_reset_mid;
        logic [4:0] exp_e;
        for (int i = 0; i < 46; i++) begin
            step(i == 25, REL & ~5'b00010, 5'b00010);
            exp_e = m_edge;
            if (i >= 25 && i <= 32) exp_e = 5'b00000;
            if (i == 33) exp_e = 5'b00010;
            tests++;
            if ((i >= 25 && i <= 31 && bus.BTN_PRESSED !== 5'h0) || (i == 25 && bus.EVT_DROPPED !== 1'b0) ||
                bus.BTN_EDGE !== exp_e || bus.BTN_PRESSED !== m_lvl) begin
                fails++;
                $display("FAIL reset_mid i=%0d: pressed=%b edge=%b drop=%b, required pressed=%b edge=%b",
                         i, bus.BTN_PRESSED, bus.BTN_EDGE, bus.EVT_DROPPED, m_lvl, exp_e);
            end
        end
        settle(12);
    endtask

    task automatic test_coalesce;
        int dut_drops = 0;
        int ref_drops = 0;
        logic [4:0] en;
        for (int i = 0; i < 70; i++) begin
            en = (i < 30) ? 5'b00111 : {2'b00, 1'b1, 1'(i % 2), 1'(~i % 2)};
            step(1'b0, REL & ~5'b00111, en);
            dut_drops += int'(bus.EVT_DROPPED);
            ref_drops += int'(m_drop);
            tests++;
            if (bus.BTN_EDGE !== m_edge || bus.EVT_DROPPED !== m_drop || bus.BTN_PRESSED !== m_lvl) begin
                fails++;
                $display("FAIL coalesce i=%0d: edge=%b drop=%b pressed=%b, required %b %b %b",
                         i, bus.BTN_EDGE, bus.EVT_DROPPED, bus.BTN_PRESSED, m_edge, m_drop, m_lvl);
            end
        end
        tests++;
        if (dut_drops !== ref_drops) begin
            fails++;
            $display("FAIL coalesce_count: dropped=%0d, required %0d", dut_drops, ref_drops);
        end
        settle(12);
    endtask

    task automatic test_random;
        logic [4:0] pins = REL;
        logic [4:0] en   = 5'h00;
        logic       r;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) pins[$urandom_range(0, 4)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) en = 5'($urandom);
            r = ($urandom_range(0, 499) == 0);
            step(r, pins, en);
            tests++;
            if (bus.BTN_EDGE !== m_edge || bus.EVT_DROPPED !== m_drop || bus.BTN_PRESSED !== m_lvl) begin
                fails++;
                $display("FAIL random i=%0d: edge=%b drop=%b pressed=%b, required %b %b %b",
                         i, bus.BTN_EDGE, bus.EVT_DROPPED, bus.BTN_PRESSED, m_edge, m_drop, m_lvl);
            end
        end
        settle(12);
    endtask

    initial begin
        bus.BTN_RAW   = REL;
        bus.REPEAT_EN = 5'h00;
        test_reset();
        test_single_press();
        test_repeat();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_coalesce();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
